// File: rtl/usb_init_seq.sv
// USB controller power-up sequencer: holds the chip in reset, waits for it to settle, then waits for ready.
// Optional chip-ready timeout with chip-reset retries is enabled by defining USB_INIT_TIMEOUT_EN.
module usb_init_seq #(
   parameter int RST_CYCLES     = 1000,
   parameter int SETTLE_CYCLES  = 10000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       usb_clk,
   input  logic       i_rst,
   input  logic       i_pll_locked,
   input  logic       i_reinit,
   input  logic       i_chip_ready,
   output logic       o_usb_rstn,
   output logic       o_init_done,
   output logic       o_init_fail,
   output logic [1:0] o_retry_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHIP_RST = 3'd1,
      SETTLE   = 3'd2,
      WAIT_RDY = 3'd3,
      DONE     = 3'd4,
      FAIL     = 3'd5
   } state_t;

   localparam int RS_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
`ifdef USB_INIT_TIMEOUT_EN
   localparam int CNT_MAX = (TIMEOUT_CYCLES > RS_MAX) ? TIMEOUT_CYCLES : RS_MAX;
`else
   localparam int CNT_MAX = RS_MAX;
`endif
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef USB_INIT_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]    RETRY_LIM   = 2'(MAX_RETRY);
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      retry_q, retry_d;
   logic            rstn_q, rstn_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;
   logic            counting_s;

   // Next state and retry count; pll loss beats re-init, which beats the normal sequence.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if ((state_q != IDLE) && !i_pll_locked) begin
         state_d = IDLE;
         retry_d = 2'd0;
      end else if (((state_q == DONE) || (state_q == FAIL)) && i_reinit) begin
         state_d = CHIP_RST;
         retry_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_pll_locked) state_d = CHIP_RST;
               else              state_d = IDLE;
            end
            CHIP_RST: begin
               if (cnt_q == RST_LAST) state_d = SETTLE;
               else                   state_d = CHIP_RST;
            end
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) state_d = WAIT_RDY;
               else                      state_d = SETTLE;
            end
            WAIT_RDY: begin
               if (i_chip_ready) begin
                  state_d = DONE;
`ifdef USB_INIT_TIMEOUT_EN
               end else if (cnt_q == TO_LAST) begin
                  if (retry_q < RETRY_LIM) begin
                     state_d = CHIP_RST;
                     retry_d = retry_q + 2'd1;
                  end else begin
                     state_d = FAIL;
                  end
`endif
               end else begin
                  state_d = WAIT_RDY;
               end
            end
            DONE:    state_d = DONE;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end
   end

   // Shared cycle counter: restarts on every state change and saturates instead of wrapping.
   always_comb begin
      counting_s = 1'b0;
      case (state_q)
         CHIP_RST: counting_s = 1'b1;
         SETTLE:   counting_s = 1'b1;
`ifdef USB_INIT_TIMEOUT_EN
         WAIT_RDY: counting_s = 1'b1;
`endif
         default:  counting_s = 1'b0;
      endcase
      if (state_d != state_q) begin
         cnt_d = {CW{1'b0}};
      end else if (counting_s && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output values decoded from the upcoming state so the registered outputs track the state.
   always_comb begin
      rstn_d = (state_d != IDLE) && (state_d != CHIP_RST);
      done_d = (state_d == DONE);
`ifdef USB_INIT_TIMEOUT_EN
      fail_d = (state_d == FAIL);
`else
      fail_d = 1'b0;
`endif
   end

   // State, counter and output registers.
   always_ff @(posedge usb_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         retry_q <= 2'd0;
         rstn_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         rstn_q  <= rstn_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign o_usb_rstn  = rstn_q;
   assign o_init_done = done_q;
   assign o_init_fail = fail_q;
   assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_usb_init_seq.sv
// Bench for usb_init_seq: directed scenarios plus random traffic, checked against a timeline model.
module tb_usb_init_seq;
   localparam int RST_C = 4;
   localparam int SET_C = 8;
   localparam int TO_C  = 16;
   localparam int MR    = 2;
`ifdef USB_INIT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       usb_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_pll_locked = 1'b0;
   logic       i_reinit = 1'b0;
   logic       i_chip_ready = 1'b0;
   logic       o_usb_rstn, o_init_done, o_init_fail;
   logic [1:0] o_retry_cnt;

   int tests = 0;
   int fails = 0;

   // Model: m_t is cycles since the current chip-reset attempt began.
   bit m_active, m_done, m_fail;
   int m_t, m_retry;

   always #5 usb_clk = ~usb_clk;

   usb_init_seq #(
      .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .TIMEOUT_CYCLES(TO_C), .MAX_RETRY(MR)
   ) dut (
      .usb_clk(usb_clk), .i_rst(i_rst), .i_pll_locked(i_pll_locked), .i_reinit(i_reinit),
      .i_chip_ready(i_chip_ready), .o_usb_rstn(o_usb_rstn), .o_init_done(o_init_done),
      .o_init_fail(o_init_fail), .o_retry_cnt(o_retry_cnt)
   );

   function automatic void model_clear();
      m_active = 1'b0; m_done = 1'b0; m_fail = 1'b0; m_t = 0; m_retry = 0;
   endfunction

   task automatic model_step();
      int w;
      if (i_rst) begin
         model_clear();
      end else if (!m_active) begin
         if (i_pll_locked) begin m_active = 1'b1; m_t = 0; end
      end else if (!i_pll_locked) begin
         model_clear();
      end else if (m_done || m_fail) begin
         if (i_reinit) begin m_t = 0; m_retry = 0; m_done = 1'b0; m_fail = 1'b0; end
      end else if (m_t >= RST_C + SET_C) begin
         w = m_t - RST_C - SET_C;
         if (i_chip_ready) m_done = 1'b1;
         else if (TO_EN && (w == TO_C - 1)) begin
            if (m_retry < MR) begin m_retry++; m_t = 0; end
            else m_fail = 1'b1;
         end else m_t++;
      end else begin
         m_t++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic exp_rstn;
      exp_rstn = m_active && (m_done || m_fail || (m_t >= RST_C));
      chk({tag, "/rstn"},  32'(o_usb_rstn),  32'(exp_rstn));
      chk({tag, "/done"},  32'(o_init_done), 32'(m_done));
      chk({tag, "/fail"},  32'(o_init_fail), 32'(m_fail));
      chk({tag, "/retry"}, 32'(o_retry_cnt), 32'(m_retry));
   endtask

   task automatic tick(input string tag);
      @(posedge usb_clk);
      model_step();
      #1;
      check_model(tag);
   endtask

   initial begin
      int  n;
      int  falls;
      logic prev;
      logic [1:0] seen [3];
      model_clear();
      #1 i_rst = 1'b1;
      #2 check_model("reset");
      tick("reset_hold");
      tick("reset_hold");
      i_rst = 1'b0;

      // Boot with pll locked and chip ready from the start.
      i_pll_locked = 1'b1; i_chip_ready = 1'b1;
      n = 0;
      while (o_usb_rstn !== 1'b1 && n < 50) begin tick("boot"); n++; end
      chk("boot_rstn_low_cycles", n, 32'(RST_C + 1));
      n = 0;
      while (o_init_done !== 1'b1 && n < 50) begin tick("boot"); n++; end
      chk("boot_rstn_high_to_done", n, 32'(SET_C + 1));

      // Re-init, then a one-cycle pll drop in SETTLE restarts the whole sequence.
      i_reinit = 1'b1; tick("reinit_done"); i_reinit = 1'b0;
      repeat (RST_C + 2) tick("to_settle");
      chk("pre_drop_rstn", 32'(o_usb_rstn), 32'd1);
      i_pll_locked = 1'b0; tick("pll_drop"); i_pll_locked = 1'b1;
      chk("pll_drop_rstn", 32'(o_usb_rstn), 32'd0);
      n = 0;
      while (o_init_done !== 1'b1 && n < 50) begin tick("restart"); n++; end
      chk("restart_to_done", n, 32'(1 + RST_C + SET_C + 1));

      // Chip never ready.
      i_chip_ready = 1'b0;
      i_reinit = 1'b1; tick("reinit_nordy"); i_reinit = 1'b0;
`ifdef USB_INIT_TIMEOUT_EN
      falls = 1; seen[0] = o_retry_cnt; prev = o_usb_rstn;
      n = 0;
      while (o_init_fail !== 1'b1 && n < 200) begin
         tick("retry");
         n++;
         if (prev && !o_usb_rstn) begin
            if (falls < 3) seen[falls] = o_retry_cnt;
            falls++;
         end
         prev = o_usb_rstn;
      end
      chk("retry_to_fail_cycles", n, 32'(3 * (RST_C + SET_C + TO_C)));
      chk("chip_rst_pulses", falls, 32'd3);
      chk("retry_seq0", 32'(seen[0]), 32'd0);
      chk("retry_seq1", 32'(seen[1]), 32'd1);
      chk("retry_seq2", 32'(seen[2]), 32'd2);
      i_reinit = 1'b1; tick("reinit_fail"); i_reinit = 1'b0;
      chk("reinit_fail_clear", 32'(o_init_fail), 32'd0);
      chk("reinit_retry_clear", 32'(o_retry_cnt), 32'd0);
`else
      repeat (100) tick("wait_forever");
      chk("no_timeout_done", 32'(o_init_done), 32'd0);
      chk("no_timeout_fail", 32'(o_init_fail), 32'd0);
      i_pll_locked = 1'b0; tick("restart_drop"); i_pll_locked = 1'b1;
      tick("restart_go");
`endif

      // Ready arrives on exactly the last cycle of the wait window.
      repeat (RST_C + SET_C + TO_C - 1) tick("late_rdy");
      i_chip_ready = 1'b1; tick("late_rdy_hit");
      chk("late_rdy_done", 32'(o_init_done), 32'd1);
      chk("late_rdy_retry", 32'(o_retry_cnt), 32'd0);

      // Asynchronous reset in DONE, observed before any clock edge.
      #3 i_rst = 1'b1;
      #1 model_clear();
      check_model("async_done");
      tick("async_done_hold");
      i_rst = 1'b0;

      // Re-init in CHIP_RST is ignored; then async reset in CHIP_RST.
      tick("boot2");
      tick("boot2");
      i_reinit = 1'b1; tick("reinit_in_rst"); i_reinit = 1'b0;
      tick("boot2");
      chk("chiprst_rstn", 32'(o_usb_rstn), 32'd0);
      repeat (2) tick("boot2");
      chk("reinit_ignored_rstn", 32'(o_usb_rstn), 32'd1);
      repeat (RST_C - 2) tick("boot3_prep");
      #3 i_rst = 1'b1;
      #1 model_clear();
      check_model("async_chiprst");
      tick("async_chiprst_hold");
      i_rst = 1'b0;

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         i_pll_locked = ($urandom_range(0, 59) != 0);
         i_chip_ready = ($urandom_range(0, 11) == 0);
         i_reinit     = ($urandom_range(0, 15) == 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/usb_init_seq.md
USB_INIT_SEQ -- requirements
Module: usb_init_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 1000: cycles the external USB chip reset is held low.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 10000: wait after chip reset release before chip-ready is sampled.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000: chip-ready wait limit (timeout build only).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, range 1..3: chip-reset retries before failure (timeout build only).
REQ-005 The block SHALL have port usb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high (driven from o_rst_usbclk).
REQ-007 The block SHALL have port i_pll_locked, input, 1 bit: clock-source lock, already synchronous to usb_clk.
REQ-008 The block SHALL have port i_reinit, input, 1 bit: single-cycle re-initialisation request.
REQ-009 The block SHALL have port i_chip_ready, input, 1 bit: USB controller ready flag, already synchronous to usb_clk.
REQ-010 The block SHALL have port o_usb_rstn, output, 1 bit: external USB controller reset, active-low.
REQ-011 The block SHALL have port o_init_done, output, 1 bit: initialisation complete.
REQ-012 The block SHALL have port o_init_fail, output, 1 bit: initialisation failed after all retries.
REQ-013 The block SHALL have port o_retry_cnt, output, 2 bits: retries used in the current attempt.

Function
REQ-014 All outputs SHALL be registered, and the FSM SHALL have the states IDLE, CHIP_RST, SETTLE, WAIT_RDY, DONE and FAIL.
REQ-015 IDLE SHALL go to CHIP_RST on the edge where i_pll_locked=1.
REQ-016 CHIP_RST SHALL last exactly RST_CYCLES cycles, then go to SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to WAIT_RDY.
REQ-018 WAIT_RDY SHALL go to DONE on the edge where i_chip_ready=1, and i_chip_ready SHALL be ignored in all other states.
REQ-019 o_usb_rstn SHALL be 0 in IDLE and CHIP_RST and 1 in SETTLE, WAIT_RDY, DONE and FAIL.
REQ-020 o_init_done SHALL be 1 only in DONE, and o_init_fail SHALL be 1 only in FAIL.
REQ-021 i_pll_locked=0 in any state other than IDLE SHALL force IDLE on the next edge, clearing the cycle counter and o_retry_cnt.
REQ-022 i_reinit=1 in DONE or FAIL SHALL go to CHIP_RST, clear o_retry_cnt, and drop o_init_done/o_init_fail on that edge; i_reinit in any other state SHALL be ignored.
REQ-023 Priority SHALL be: pll loss > i_reinit > normal transition.
REQ-024 A single shared cycle counter SHALL be sized to $clog2 of the largest used count plus 1, SHALL be cleared on every state entry, and SHALL never wrap.

Reset
REQ-025 i_rst=1 SHALL asynchronously force state=IDLE, counter=0, o_usb_rstn=0, o_init_done=0, o_init_fail=0 and o_retry_cnt=0.
REQ-026 After i_rst deasserts, the FSM SHALL start from IDLE; reset mid-sequence SHALL abort with no residual state.

Configuration
REQ-027 With macro USB_INIT_TIMEOUT_EN defined, WAIT_RDY SHALL count cycles; after TIMEOUT_CYCLES cycles without ready, it SHALL go to CHIP_RST with o_retry_cnt+1 if o_retry_cnt<MAX_RETRY, and to FAIL otherwise.
REQ-028 With USB_INIT_TIMEOUT_EN defined, i_chip_ready=1 on the timeout cycle SHALL go to DONE, because ready wins.
REQ-029 Without USB_INIT_TIMEOUT_EN, WAIT_RDY SHALL wait indefinitely, FAIL SHALL be unreachable, o_init_fail and o_retry_cnt SHALL be tied 0, and TIMEOUT_CYCLES/MAX_RETRY SHALL be unused.

Verification (RST_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=16, MAX_RETRY=2)
REQ-030 The bench SHALL cover: i_pll_locked=1 and i_chip_ready=1 from start -> o_usb_rstn low exactly 5 cycles (IDLE + 4), high 8 cycles before WAIT_RDY, o_init_done=1 one cycle after WAIT_RDY entry.
REQ-031 The bench SHALL cover: i_pll_locked dropped for 1 cycle during SETTLE -> o_usb_rstn=0 the next cycle, full sequence restarts, and o_init_done stays 0 until the new sequence completes.
REQ-032 The bench SHALL cover, timeout build: i_chip_ready held 0 -> 3 chip-reset pulses, o_retry_cnt steps 0,1,2, o_init_fail=1 after the third 16-cycle wait; then i_reinit pulse -> o_init_fail=0 and o_retry_cnt=0 next cycle.
REQ-033 The bench SHALL cover, timeout build: i_chip_ready rises on exactly the 16th WAIT_RDY cycle -> DONE, with no retry.
REQ-034 The bench SHALL cover: i_rst asserted asynchronously mid-CHIP_RST and mid-DONE -> all outputs reach reset values without a clock edge; i_reinit pulsed during CHIP_RST has no effect.
